frame_scanner: RTL and testbench
================================

FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 SHALL have parameter H_VISIBLE, 800, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, 40; H_SYNC, 48; H_BACK, 40 (horizontal porches/sync, in pixels).
REQ-003 SHALL have parameter V_VISIBLE, 480; V_FRONT, 13; V_SYNC, 3; V_BACK, 29 (vertical, in lines).
REQ-004 SHALL have parameter COOR_WIDTH, 12, width of the coordinate outputs.
REQ-005 SHALL have parameter READ_LATENCY, 2, number of cycles from address to fb_read_palette valid (range 1..4).
REQ-006 SHALL have ports:
- clk_33m  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- fb_read_x  out  COOR_WIDTH  framebuffer read column.
- fb_read_y  out  COOR_WIDTH  framebuffer read row.
- fb_read_buffer  out  1  buffer currently displayed; the painter writes the other one.
- fb_read_palette  in  2  palette index returned READ_LATENCY cycles after the address.
- painter_finished  in  1  level signal: painter has completed the back buffer.
- paint_start  out  1  one-cycle pulse that restarts the painter (drives painter rst).
- hsync, vsync  out  1  active-low syncs.
- de  out  1  data enable.
- red, green, blue  out  8 each  pixel colour.

Function
REQ-007 SHALL keep h_count in 0..H_TOTAL-1 (H_TOTAL = sum of the H params): increment every cycle and wrap to 0; on wrap, v_count SHALL increment and wrap at V_TOTAL-1.
REQ-008 SHALL drive fb_read_x = h_count and fb_read_y = v_count directly from the counter registers (zero-extended).
REQ-009 SHALL derive raw timing at the counter stage:
- visible = h_count<H_VISIBLE && v_count<V_VISIBLE.
- hs_raw active for h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
- vs_raw analogous on v_count.
REQ-010 SHALL delay visible/hs_raw/vs_raw through a READ_LATENCY+1 stage shift register so that de/hsync/vsync align with the colour outputs.
REQ-011 SHALL register the colour one cycle after fb_read_palette is valid, using this map:
- 0 -> F7F7F7
- 1 -> 535353
- 2 -> DADADA
- 3 -> FFFFFF
REQ-012 SHALL force red/green/blue to 0 in any cycle where the aligned de is 0.
REQ-013 SHALL have a total latency of READ_LATENCY+1 cycles from a counter value to the corresponding de/hsync/vsync/rgb outputs.
REQ-014 SHALL hold a frame_ready flag, set on a rising edge of painter_finished (painter_finished=1 and its previous-cycle value=0); level-high without an edge SHALL NOT set it.
REQ-015 SHALL define the swap point as the cycle in which h_count==0 and v_count==V_VISIBLE (vblank start).
REQ-016 At the swap point with frame_ready=1, SHALL:
- toggle fb_read_buffer.
- clear frame_ready.
- pulse paint_start for exactly one cycle.
REQ-017 At the swap point with frame_ready=0, SHALL keep fb_read_buffer, assert no paint_start, and redisplay the same buffer.
REQ-018 If a painter_finished rising edge coincides with the swap point, SHALL perform the swap in that cycle (edge counts as ready).
REQ-019 SHALL change fb_read_buffer only at the swap point, never during visible lines.
REQ-020 SHALL pulse paint_start for exactly one cycle in the first cycle after rst deasserts (initial paint), independent of the swap point.
REQ-021 SHALL never pulse paint_start in two consecutive cycles.

Reset
REQ-022 While rst=1, SHALL hold:
- h_count=0, v_count=0.
- fb_read_buffer=0.
- frame_ready=0 and the previous-painter_finished register=0.
- paint_start=0.
- pipeline cleared: de=0, hsync=1, vsync=1, rgb=0.
REQ-023 Reset asserted mid-frame or mid-swap SHALL take effect on the next edge with no partial swap retained.

Verification
REQ-024 Release reset, hold painter_finished=0 -> paint_start=1 only in cycle 1 after release; de first rises at cycle READ_LATENCY+1; hsync low for 48 cycles beginning at cycle 840+READ_LATENCY+1 from release.
REQ-025 Full-frame check -> exactly 928*525=487200 cycles per frame, 480 de lines of 800 cycles each, vsync low for 3*928 cycles.
REQ-026 Drive fb_read_palette=1 for all reads -> rgb=535353 whenever de=1 and 000000 whenever de=0; palette=3 -> FFFFFF.
REQ-027 Raise painter_finished mid-frame and hold it -> at the next h=0,v=480 cycle fb_read_buffer 0->1 and paint_start=1 for one cycle; with painter_finished still held high (no new edge), no swap at the following vblank.
REQ-028 Painter_finished rising edge exactly at the swap cycle -> swap in that cycle; rising edge one cycle after the swap cycle -> swap deferred to the next frame.
REQ-029 Assert rst at h=300,v=200 for one cycle -> counters at 0 and outputs at reset values, then the REQ-024 behaviour repeats.

Source files
------------

// File: rtl/frame_scanner.sv
// frame_scanner: raster timing generator and double-buffered framebuffer scan-out.
//
// Ports:
//   clk_33m           sole clock
//   rst               synchronous active-high reset
//   fb_read_x/_y      framebuffer read address (raw h/v counters)
//   fb_read_buffer    buffer being displayed; the painter owns the other one
//   fb_read_palette   palette index, valid READ_LATENCY cycles after the address
//   painter_finished  level: painter has completed the back buffer
//   paint_start       one-cycle painter restart pulse
//   hsync, vsync      active-low syncs, aligned with the colour outputs
//   de                data enable, aligned with the colour outputs
//   red/green/blue    pixel colour, forced to zero outside the visible area
//
// Pipeline: the counters are stage 0; de/hsync/vsync/rgb appear
// READ_LATENCY+1 cycles later. Buffer swaps and paint_start are registered,
// so they become visible in the cycle after the swap point (h=0, v=V_VISIBLE).
module frame_scanner #(
    parameter int H_VISIBLE    = 800,
    parameter int H_FRONT      = 40,
    parameter int H_SYNC       = 48,
    parameter int H_BACK       = 40,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 13,
    parameter int V_SYNC       = 3,
    parameter int V_BACK       = 29,
    parameter int COOR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_33m,
    input  logic                  rst,
    output logic [COOR_WIDTH-1:0] fb_read_x,
    output logic [COOR_WIDTH-1:0] fb_read_y,
    output logic                  fb_read_buffer,
    input  logic [1:0]            fb_read_palette,
    input  logic                  painter_finished,
    output logic                  paint_start,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COOR_WIDTH-1:0] H_LAST  = COOR_WIDTH'(H_TOTAL - 1);
    localparam logic [COOR_WIDTH-1:0] V_LAST  = COOR_WIDTH'(V_TOTAL - 1);
    localparam logic [COOR_WIDTH-1:0] H_VIS   = COOR_WIDTH'(H_VISIBLE);
    localparam logic [COOR_WIDTH-1:0] V_VIS   = COOR_WIDTH'(V_VISIBLE);
    localparam logic [COOR_WIDTH-1:0] HS_BEG  = COOR_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COOR_WIDTH-1:0] HS_END  = COOR_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COOR_WIDTH-1:0] VS_BEG  = COOR_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COOR_WIDTH-1:0] VS_END  = COOR_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COOR_WIDTH-1:0] h_count_q, h_count_d;
    logic [COOR_WIDTH-1:0] v_count_q, v_count_d;
    logic                  buf_q, buf_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  pf_prev_q;
    logic                  paint_start_q, paint_start_d;
    logic                  init_q;
    logic [READ_LATENCY:0] de_pipe_q, de_pipe_d;
    logic [READ_LATENCY:0] hs_pipe_q, hs_pipe_d;
    logic [READ_LATENCY:0] vs_pipe_q, vs_pipe_d;
    logic [7:0]            rgb_q, rgb_d;

    logic visible, hs_raw, vs_raw;
    logic pf_edge, swap_point, do_swap;
    logic [7:0] gray;

    always_comb begin
        h_count_d = h_count_q + 1'b1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
        end

        visible = (h_count_q < H_VIS) && (v_count_q < V_VIS);
        hs_raw  = (h_count_q >= HS_BEG) && (h_count_q < HS_END);
        vs_raw  = (v_count_q >= VS_BEG) && (v_count_q < VS_END);

        de_pipe_d = {de_pipe_q[READ_LATENCY-1:0], visible};
        hs_pipe_d = {hs_pipe_q[READ_LATENCY-1:0], hs_raw};
        vs_pipe_d = {vs_pipe_q[READ_LATENCY-1:0], vs_raw};

        // An edge arriving in the swap cycle itself counts as ready.
        pf_edge    = painter_finished & ~pf_prev_q;
        swap_point = (h_count_q == '0) && (v_count_q == V_VIS);
        do_swap    = swap_point & (frame_ready_q | pf_edge);

        buf_d         = buf_q ^ do_swap;
        paint_start_d = init_q | do_swap;
        frame_ready_d = frame_ready_q;
        if (do_swap) begin
            frame_ready_d = 1'b0;
        end else if (pf_edge) begin
            frame_ready_d = 1'b1;
        end

        unique case (fb_read_palette)
            2'd0:    gray = 8'hF7;
            2'd1:    gray = 8'h53;
            2'd2:    gray = 8'hDA;
            default: gray = 8'hFF;
        endcase
        // Palette data for a pixel is present while its de bit sits one
        // stage short of the output, so gate with that stage.
        rgb_d = de_pipe_q[READ_LATENCY-1] ? gray : '0;
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            buf_q         <= 1'b0;
            frame_ready_q <= 1'b0;
            pf_prev_q     <= 1'b0;
            paint_start_q <= 1'b0;
            init_q        <= 1'b1;
            de_pipe_q     <= '0;
            hs_pipe_q     <= '0;
            vs_pipe_q     <= '0;
            rgb_q         <= '0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            buf_q         <= buf_d;
            frame_ready_q <= frame_ready_d;
            pf_prev_q     <= painter_finished;
            paint_start_q <= paint_start_d;
            init_q        <= 1'b0;
            de_pipe_q     <= de_pipe_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            rgb_q         <= rgb_d;
        end
    end

    assign fb_read_x      = h_count_q;
    assign fb_read_y      = v_count_q;
    assign fb_read_buffer = buf_q;
    assign paint_start    = paint_start_q;
    assign de             = de_pipe_q[READ_LATENCY];
    assign hsync          = ~hs_pipe_q[READ_LATENCY];
    assign vsync          = ~vs_pipe_q[READ_LATENCY];
    assign red            = rgb_q;
    assign green          = rgb_q;
    assign blue           = rgb_q;

endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: randomized self-checking bench for frame_scanner, using a
// reduced raster so that many frames fit in a short run.
module tb_frame_scanner;

    localparam int HV = 16, HF = 4, HS = 6, HB = 3;
    localparam int VV = 8,  VF = 2, VS = 3, VB = 2;
    localparam int CW = 12, RL = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int SWAP0 = VV * HT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pf  = 1'b0;
    logic [1:0]    pal = 2'd0;
    logic [CW-1:0] fb_x, fb_y;
    logic          fb_buf, ps, hsync, vsync, de;
    logic [7:0]    red, green, blue;

    frame_scanner #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COOR_WIDTH(CW), .READ_LATENCY(RL)
    ) dut (
        .clk_33m(clk), .rst(rst),
        .fb_read_x(fb_x), .fb_read_y(fb_y), .fb_read_buffer(fb_buf),
        .fb_read_palette(pal), .painter_finished(pf), .paint_start(ps),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input logic [1:0] p);
        case (p)
            2'd0:    return 32'hF7;
            2'd1:    return 32'h53;
            2'd2:    return 32'hDA;
            default: return 32'hFF;
        endcase
    endfunction

    // Model state: n is the cycle index since reset release (0 while in reset).
    int         n = 0;
    int         mode = 0;
    bit         m_buf, m_ready, m_prev, m_ps, m_init;
    logic [1:0] hist[$];

    initial begin : model_proc
        bit edge_pf, sp, sw, ex_de, ex_hs, ex_vs;
        int s, sh, sv, ex_rgb, cnt_de, cnt_vs, pix;
        logic [1:0] d;
        cnt_de = 0;
        cnt_vs = 0;
        for (int i = 0; i < 8; i++) hist.push_back(2'd0);
        forever begin
            @(posedge clk);
            #1;
            // Advance with the inputs of the cycle just ended.
            if (rst) begin
                n = 0; m_buf = 0; m_ready = 0; m_prev = 0; m_ps = 0; m_init = 1;
            end else begin
                edge_pf = pf && !m_prev;
                m_prev  = pf;
                sp      = (n % HT == 0) && ((n / HT) % VT == VV);
                sw      = sp && (m_ready || edge_pf);
                m_ps    = m_init || sw;
                m_init  = 0;
                if (sw) begin
                    m_buf = !m_buf;
                    m_ready = 0;
                end else if (edge_pf) begin
                    m_ready = 1;
                end
                n++;
            end

            // Expected outputs for the current cycle.
            if (n >= RL + 1) begin
                s      = n - RL - 1;
                sh     = s % HT;
                sv     = (s / HT) % VT;
                ex_de  = (sh < HV) && (sv < VV);
                ex_hs  = !((sh >= HV + HF) && (sh < HV + HF + HS));
                ex_vs  = !((sv >= VV + VF) && (sv < VV + VF + VS));
                ex_rgb = ex_de ? gray(hist[RL]) : 0;
            end else begin
                ex_de = 0; ex_hs = 1; ex_vs = 1; ex_rgb = 0;
            end
            check("fb_read_x", int'(fb_x), n % HT);
            check("fb_read_y", int'(fb_y), (n / HT) % VT);
            check("fb_read_buffer", int'(fb_buf), int'(m_buf));
            check("paint_start", int'(ps), int'(m_ps));
            check("de", int'(de), int'(ex_de));
            check("hsync", int'(hsync), int'(ex_hs));
            check("vsync", int'(vsync), int'(ex_vs));
            check("red", int'(red), ex_rgb);
            check("green", int'(green), ex_rgb);
            check("blue", int'(blue), ex_rgb);

            // Hand-computed pins for the first line after release.
            if (n == 1)  check("init_paint_pulse", int'(ps), 1);
            if (n == 2)  check("init_paint_single", int'(ps), 0);
            if (n == RL) check("de_before_first", int'(de), 0);
            if (n == RL + 1) check("de_first_rise", int'(de), 1);
            if (n == HV + HF + RL)          check("hsync_pre", int'(hsync), 1);
            if (n == HV + HF + RL + 1)      check("hsync_fall", int'(hsync), 0);
            if (n == HV + HF + HS + RL)     check("hsync_last_low", int'(hsync), 0);
            if (n == HV + HF + HS + RL + 1) check("hsync_rise", int'(hsync), 1);

            // Whole-frame totals over the first output frame.
            if (n == RL + 1) begin
                cnt_de = 0;
                cnt_vs = 0;
            end
            if (n >= RL + 1 && n < RL + 1 + FRAME) begin
                cnt_de += int'(de);
                cnt_vs += int'(!vsync);
            end
            if (n == RL + 1 + FRAME) begin
                check("frame_de_cycles", cnt_de, 128);
                check("frame_vsync_low_cycles", cnt_vs, 87);
            end

            // Framebuffer model: answer the current address after RL cycles.
            pix = int'(fb_x) + 2 * int'(fb_y) + int'(fb_buf);
            case (mode)
                0:       d = pix[1:0];
                1:       d = 2'd1;
                2:       d = 2'd3;
                default: d = 2'($urandom_range(3));
            endcase
            hist.push_front(d);
            void'(hist.pop_back());
            pal = hist[RL];
        end
    end

    task automatic wait_until(input int target);
        int budget;
        budget = 3 * FRAME;
        while (n != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (n != target) begin
            n_fail++;
            $display("FAIL wait_cycle: got %0d, expected %0d", n, target);
        end
    endtask

    initial begin : stim
        int t;
        rst = 1; pf = 0; mode = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        wait_until(SWAP0 + 5);
        check("no_swap_without_ready", int'(fb_buf), 0);

        wait_until(FRAME);
        mode = 1;
        wait_until(FRAME + RL + 1 + 3);
        check("pal1_de", int'(de), 1);
        check("pal1_red", int'(red), 32'h53);
        check("pal1_blue", int'(blue), 32'h53);
        wait_until(FRAME + RL + 1 + HV + 1);
        check("pal1_blank_de", int'(de), 0);
        check("pal1_blank_rgb", int'(green), 0);

        wait_until(2 * FRAME);
        mode = 2;
        wait_until(2 * FRAME + RL + 1 + 5);
        check("pal3_red", int'(red), 32'hFF);

        // Painter finishes mid-frame and holds the level.
        wait_until(3 * FRAME + 3 * HT);
        mode = 0;
        pf = 1;
        wait_until(3 * FRAME + SWAP0);
        check("swap_not_yet", int'(fb_buf), 0);
        wait_until(3 * FRAME + SWAP0 + 1);
        check("swap_buf", int'(fb_buf), 1);
        check("swap_paint", int'(ps), 1);
        wait_until(3 * FRAME + SWAP0 + 2);
        check("swap_paint_single", int'(ps), 0);
        wait_until(4 * FRAME + SWAP0 + 2);
        check("held_level_no_swap", int'(fb_buf), 1);

        // Rising edge exactly in the swap cycle.
        wait_until(4 * FRAME + SWAP0 + 10);
        pf = 0;
        wait_until(5 * FRAME + SWAP0);
        pf = 1;
        wait_until(5 * FRAME + SWAP0 + 1);
        check("edge_at_swap_buf", int'(fb_buf), 0);
        check("edge_at_swap_paint", int'(ps), 1);

        // Rising edge one cycle late defers to the next frame.
        wait_until(5 * FRAME + SWAP0 + 10);
        pf = 0;
        wait_until(6 * FRAME + SWAP0 + 1);
        pf = 1;
        wait_until(6 * FRAME + SWAP0 + 2);
        check("late_edge_no_swap", int'(fb_buf), 0);
        wait_until(7 * FRAME + SWAP0 + 1);
        check("late_edge_next_buf", int'(fb_buf), 1);
        check("late_edge_next_paint", int'(ps), 1);

        // Random palette and painter activity.
        mode = 3;
        repeat (4 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(63) == 0) pf = ~pf;
        end

        // One-cycle reset mid-frame.
        pf = 0;
        t = (n / FRAME + 1) * FRAME + 5 * HT + 10;
        wait_until(t);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_x", int'(fb_x), 0);
        check("rst_y", int'(fb_y), 0);
        check("rst_buf", int'(fb_buf), 0);
        check("rst_de", int'(de), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_rgb", int'(red), 0);
        wait_until(RL + 1 + FRAME + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
